// File: rtl/mm_pkg.sv
// Shared types and constants for the result drain path.
// DRAIN_CHECKSUM_EN adds a checksum word per block and one address MSB.
package mm_pkg;

  localparam int DATA_W  = 16;
  localparam int LANES   = 16;
  localparam int BLK_W   = 4;
  localparam int LANE_W  = $clog2(LANES);
  localparam int BLOCK_W = DATA_W * LANES;
`ifdef DRAIN_CHECKSUM_EN
  localparam int ADDR_W  = BLK_W + LANE_W + 1;
`else
  localparam int ADDR_W  = BLK_W + LANE_W;
`endif

  typedef enum logic [1:0] {IDLE, DRAIN, CSUM} drain_state_e;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [DATA_W-1:0]  elem_t;

  // Lane 0 occupies the most significant element of the block.
  function automatic elem_t lane_extract(input block_t blk, input logic [LANE_W-1:0] lane);
    return blk[(LANES-1-int'(lane))*DATA_W +: DATA_W];
  endfunction

  function automatic elem_t lane_sum(input block_t blk);
    elem_t s;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      s = s + blk[i*DATA_W +: DATA_W];
    end
    return s;
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Write-port handshake between the result drain and the output-matrix memory.
interface result_drain_if;

  logic                      wr_valid;
  logic                      wr_ready;
  mm_pkg::elem_t             wr_data;
  logic [mm_pkg::ADDR_W-1:0] wr_addr;

  modport master (output wr_valid, output wr_data, output wr_addr, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_addr, output wr_ready);

endinterface

// File: rtl/result_drain_block_slot_buf.sv
// Active + one-deep pending block storage with capture, promote and drop rules.
// A freed active slot takes the pending block first, then a fresh capture.
module block_slot_buf
  import mm_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             cap_vld,
  input  block_t           cap_blk,
  input  logic [BLK_W-1:0] cap_idx,
  input  logic             act_free,
  output block_t           act_blk,
  output logic [BLK_W-1:0] act_idx,
  output logic             act_load,
  output logic             pend_full,
  output logic             drop_err
);

  block_t           act_blk_q, act_blk_d;
  logic [BLK_W-1:0] act_idx_q, act_idx_d;
  block_t           pend_blk_q, pend_blk_d;
  logic [BLK_W-1:0] pend_idx_q, pend_idx_d;
  logic             pend_full_q, pend_full_d;
  logic             drop_err_q, drop_err_d;

  always_comb begin
    act_blk_d   = act_blk_q;
    act_idx_d   = act_idx_q;
    pend_blk_d  = pend_blk_q;
    pend_idx_d  = pend_idx_q;
    pend_full_d = pend_full_q;
    drop_err_d  = drop_err_q;
    act_load    = 1'b0;
    if (act_free && pend_full_q) begin
      act_blk_d = pend_blk_q;
      act_idx_d = pend_idx_q;
      act_load  = 1'b1;
      if (cap_vld) begin
        pend_blk_d = cap_blk;
        pend_idx_d = cap_idx;
      end else begin
        pend_full_d = 1'b0;
      end
    end else if (cap_vld) begin
      if (act_free) begin
        act_blk_d = cap_blk;
        act_idx_d = cap_idx;
        act_load  = 1'b1;
      end else if (!pend_full_q) begin
        pend_blk_d  = cap_blk;
        pend_idx_d  = cap_idx;
        pend_full_d = 1'b1;
      end else begin
        drop_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act_blk_q   <= '0;
      act_idx_q   <= '0;
      pend_blk_q  <= '0;
      pend_idx_q  <= '0;
      pend_full_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      act_blk_q   <= act_blk_d;
      act_idx_q   <= act_idx_d;
      pend_blk_q  <= pend_blk_d;
      pend_idx_q  <= pend_idx_d;
      pend_full_q <= pend_full_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign act_blk   = act_blk_q;
  assign act_idx   = act_idx_q;
  assign pend_full = pend_full_q;
  assign drop_err  = drop_err_q;

endmodule

// File: rtl/result_drain.sv
// Drains 16-lane result blocks one word per clock; first word 1 clock after done rises,
// words hold under backpressure. DRAIN_CHECKSUM_EN appends a wrapping-sum word per block.
module result_drain
  import mm_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             accumulator_done,
  input  block_t           block_in,
  input  logic [BLK_W-1:0] block_idx,
  result_drain_if.master   wr,
  output logic             busy,
  output logic             drop_err
);

  drain_state_e      state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              done_q;
  logic              done_rise, hs, last_lane, fin, act_free, act_load, pend_full;
  block_t            act_blk;
  logic [BLK_W-1:0]  act_idx;

  assign done_rise = accumulator_done & ~done_q;
  assign hs        = wr.wr_valid & wr.wr_ready;
  assign last_lane = (lane_q == LANE_W'(LANES-1));
`ifdef DRAIN_CHECKSUM_EN
  assign fin = hs & (state_q == CSUM);
`else
  assign fin = hs & last_lane;
`endif
  // Active slot is reusable on the same edge as its final handshake.
  assign act_free = (state_q == IDLE) | fin;

  block_slot_buf u_slots (
    .clock     (clock),
    .reset     (reset),
    .cap_vld   (done_rise),
    .cap_blk   (block_in),
    .cap_idx   (block_idx),
    .act_free  (act_free),
    .act_blk   (act_blk),
    .act_idx   (act_idx),
    .act_load  (act_load),
    .pend_full (pend_full),
    .drop_err  (drop_err)
  );

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      IDLE: begin
        if (act_load) begin
          state_d = DRAIN;
          lane_d  = '0;
        end
      end
      DRAIN: begin
        if (hs) begin
          lane_d = lane_q + 1'b1;
          if (last_lane) begin
`ifdef DRAIN_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = act_load ? DRAIN : IDLE;
`endif
          end
        end
      end
`ifdef DRAIN_CHECKSUM_EN
      CSUM: begin
        if (hs) begin
          lane_d  = '0;
          state_d = act_load ? DRAIN : IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      done_q  <= accumulator_done;
    end
  end

  assign wr.wr_valid = (state_q != IDLE);
`ifdef DRAIN_CHECKSUM_EN
  assign wr.wr_data = (state_q == CSUM) ? lane_sum(act_blk) : lane_extract(act_blk, lane_q);
  assign wr.wr_addr = (state_q == CSUM) ? {1'b1, act_idx, {LANE_W{1'b1}}}
                                        : {1'b0, act_idx, lane_q};
`else
  assign wr.wr_data = lane_extract(act_blk, lane_q);
  assign wr.wr_addr = {act_idx, lane_q};
`endif
  assign busy = (state_q != IDLE) | pend_full;

endmodule

// File: tb/tb_result_drain.sv
// Randomized and directed bench for result_drain against a block-queue reference model.
module tb_result_drain;
  import mm_pkg::*;

`ifdef DRAIN_CHECKSUM_EN
  localparam int WPB = LANES + 1;
`else
  localparam int WPB = LANES;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } word_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             accumulator_done;
  block_t           block_in;
  logic [BLK_W-1:0] block_idx;
  logic             busy, drop_err;

  result_drain_if wr_if ();

  result_drain dut (
    .clock            (clock),
    .reset            (reset),
    .accumulator_done (accumulator_done),
    .block_in         (block_in),
    .block_idx        (block_idx),
    .wr               (wr_if.master),
    .busy             (busy),
    .drop_err         (drop_err)
  );

  always #5 clock = ~clock;

  word_t             exp_q[$];
  int                outstanding;
  logic              exp_drop;
  logic              prev_done;
  logic              prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_addr;
  int                hs_cnt;
  int                n_chk  = 0;
  int                n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic push_block(input block_t b, input logic [BLK_W-1:0] idx);
    word_t w;
    int    sum;
    sum = 0;
    for (int k = 0; k < LANES; k++) begin
      w.data = DATA_W'(b >> ((LANES - 1 - k) * DATA_W));
      w.addr = ADDR_W'(int'(idx) * LANES + k);
      w.last = (WPB == LANES) && (k == LANES - 1);
      sum    = sum + int'(w.data);
      exp_q.push_back(w);
    end
    if (WPB != LANES) begin
      w.data = DATA_W'(sum % (1 << DATA_W));
      w.addr = ADDR_W'((1 << (BLK_W + LANE_W)) + int'(idx) * LANES + (LANES - 1));
      w.last = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  task automatic cycle(input logic rdy, input logic done);
    word_t w;
    logic  hs;
    @(negedge clock);
    wr_if.wr_ready   = rdy;
    accumulator_done = done;
    #1;
    chk("valid", wr_if.wr_valid, outstanding > 0);
    chk("busy", busy, outstanding > 0);
    chk("drop_err", drop_err, exp_drop);
    if (prev_stall) begin
      chk("hold_data", wr_if.wr_data, prev_data);
      chk("hold_addr", wr_if.wr_addr, prev_addr);
    end
    hs = wr_if.wr_valid && rdy;
    if (hs) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_word", wr_if.wr_valid, 1'b0);
      end else begin
        w = exp_q.pop_front();
        chk("wr_data", wr_if.wr_data, w.data);
        chk("wr_addr", wr_if.wr_addr, w.addr);
        if (w.last) outstanding--;
      end
    end
    prev_stall = wr_if.wr_valid && !rdy;
    prev_data  = wr_if.wr_data;
    prev_addr  = wr_if.wr_addr;
    if (done && !prev_done) begin
      if (outstanding < 2) begin
        outstanding++;
        push_block(block_in, block_idx);
      end else begin
        exp_drop = 1'b1;
      end
    end
    prev_done = done;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset            = 1'b0;
    accumulator_done = 1'b0;
    wr_if.wr_ready   = 1'b0;
    #1;
    chk("rst_valid", wr_if.wr_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop_err, 1'b0);
    chk("rst_data", wr_if.wr_data, '0);
    chk("rst_addr", wr_if.wr_addr, '0);
    exp_q.delete();
    outstanding = 0;
    exp_drop    = 1'b0;
    prev_done   = 1'b0;
    prev_stall  = 1'b0;
    hs_cnt      = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic rand_block(input logic [BLK_W-1:0] idx);
    for (int i = 0; i < LANES / 2; i++) block_in[i*32 +: 32] = $urandom();
    block_idx = idx;
  endtask

  initial begin
    reset            = 1'b0;
    accumulator_done = 1'b0;
    wr_if.wr_ready   = 1'b0;
    block_in         = '0;
    block_idx        = '0;
    do_reset();

    // Single block, lane k = k+1, idx 3, sink always ready.
    for (int k = 0; k < LANES; k++) block_in[(LANES-1-k)*DATA_W +: DATA_W] = DATA_W'(k + 1);
    block_idx = 4'd3;
    cycle(1'b1, 1'b1);
    repeat (WPB + 4) cycle(1'b1, 1'b0);
    chk("single_words", hs_cnt, WPB);

    // Backpressure pattern 1,0,0 repeating.
    do_reset();
    rand_block(4'd5);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 3 * WPB + 6; i++) cycle(i % 3 == 0, 1'b0);
    chk("bp_words", hs_cnt, WPB);

    // Back-to-back: B rises on A's 5th handshake.
    do_reset();
    rand_block(4'd1);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 2 * WPB + 8; i++) begin
      if (hs_cnt == 4 && !accumulator_done) rand_block(4'd2);
      cycle(1'b1, (hs_cnt == 4) && (i < WPB));
    end
    chk("b2b_words", hs_cnt, 2 * WPB);

    // Overflow: three rises while stalled, then drain, then a fourth block.
    do_reset();
    rand_block(4'd6);  cycle(1'b0, 1'b1); cycle(1'b0, 1'b0);
    rand_block(4'd7);  cycle(1'b0, 1'b1); cycle(1'b0, 1'b0);
    rand_block(4'd8);  cycle(1'b0, 1'b1); cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    repeat (2 * WPB + 4) cycle(1'b1, 1'b0);
    chk("ovf_words", hs_cnt, 2 * WPB);
    rand_block(4'd9);
    cycle(1'b1, 1'b1);
    repeat (WPB + 4) cycle(1'b1, 1'b0);
    chk("ovf_fourth", hs_cnt, 3 * WPB);

    // Long done level produces one capture.
    do_reset();
    rand_block(4'd10);
    repeat (40) cycle(1'b1, 1'b1);
    repeat (8) cycle(1'b1, 1'b0);
    chk("long_done_words", hs_cnt, WPB);

    // Reset after the 7th handshake abandons the block.
    do_reset();
    rand_block(4'd11);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 20 && hs_cnt < 7; i++) cycle(1'b1, 1'b0);
    chk("pre_rst_words", hs_cnt, 7);
    do_reset();
    repeat (20) cycle(1'b1, 1'b0);
    chk("post_rst_words", hs_cnt, 0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic d;
      d = accumulator_done;
      if ($urandom_range(0, 4) == 0) d = ~d;
      if (!accumulator_done) rand_block(BLK_W'($urandom()));
      cycle($urandom_range(0, 3) != 0, d);
    end
    repeat (3 * WPB + 8) cycle(1'b1, 1'b0);
    chk("rand_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
